if_fetch_unit: RTL and testbench

Instruction-fetch stage for the pipelined CPU, sitting directly in front of the IF/ID pipeline register and driving its `in_inst`, `in_pc`, `upd_pc` and `flush` inputs. Owns the program counter and issues word reads to instruction memory over a req/ack handshake with variable latency. Applies next-PC selection in priority order: exception vector, branch/jump redirect, interrupt vector, then sequential PC+4. Holds a fetched word across ID stalls and discards stale memory responses after a redirect.

---
 rtl/if_fetch_unit_pkg.sv | 22 ++
 rtl/if_fetch_unit_if.sv | 22 ++
 rtl/if_fetch_unit_npc_sel.sv | 33 +++
 rtl/if_fetch_unit.sv | 115 +++++++++++
 tb/tb_if_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM states, reset/trap vectors and PC arithmetic helpers.
// Pure declarations; no timing or flow-control behaviour of its own.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Fetch addresses are always word aligned; low bits of targets are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port: req/addr held until ack, ack may come same cycle.
// Master is the fetch unit, slave is the memory; variable-latency, one read in flight.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit_npc_sel.sv
// Next-PC priority mux: exception > redirect > user-mode irq > sequential step > hold.
// Purely combinational; no backpressure, stall is resolved by the caller via advance.
module fetch_npc_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        advance,
  input  logic        exc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        irq,
  output logic [31:0] next_pc,
  output logic        xfer,
  output logic        irq_accept
);

  always_comb begin
    // Interrupts are only taken from user mode and never compete with a higher-priority transfer.
    irq_accept = irq && !pc[31] && !exc && !redirect_valid;
    xfer       = exc || redirect_valid || irq_accept;
    next_pc    = pc;
    if (exc) begin
      next_pc = EXC_VEC;
    end else if (redirect_valid) begin
      next_pc = word_align(redirect_pc);
    end else if (irq_accept) begin
      next_pc = IRQ_VEC;
    end else if (advance) begin
      next_pc = pc + PC_STEP;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, fetches over a req/ack port, delivers to IF/ID on the ack edge.
// Stall parks one fetched word in a hold buffer; redirects flush and drop any in-flight read.
module if_fetch_unit
  import fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  input  logic                    exc,
  input  logic                    irq,
  if_fetch_unit_if.master         imem,
  output logic [31:0]             out_inst,
  output logic [31:0]             out_pc,
  output logic                    upd_pc,
  output logic                    flush,
  output logic                    irq_taken,
  output logic [31:0]             epc
);

  fetch_state_t state, next_state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic [31:0]  hold_buf;
  logic         xfer;
  logic         irq_accept;
  logic         deliver;
  logic         ack;

  assign ack     = imem.imem_ack;
  assign deliver = !stall && ((state == REQ && ack) || state == HOLD);

  fetch_npc_sel u_npc_sel (
    .pc             (pc),
    .advance        (deliver),
    .exc            (exc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .irq            (irq),
    .next_pc        (next_pc),
    .xfer           (xfer),
    .irq_accept     (irq_accept)
  );

  assign imem.imem_req  = (state == REQ);
  assign imem.imem_addr = pc;
  assign out_inst       = (state == REQ) ? imem.imem_rdata : hold_buf;
  assign out_pc         = (state == IDLE) ? pc : pc + PC_STEP;

  always_comb begin
    next_state = state;
    upd_pc     = 1'b0;
    flush      = 1'b0;
    irq_taken  = 1'b0;
    if (!reset) begin
      if (xfer) begin
        flush     = 1'b1;
        irq_taken = irq_accept;
        // A read still in flight must be drained before the new target can be requested.
        case (state)
          IDLE:    next_state = REQ;
          REQ:     next_state = ack ? REQ : DROP;
          HOLD:    next_state = REQ;
          DROP:    next_state = ack ? REQ : DROP;
          default: next_state = IDLE;
        endcase
      end else begin
        case (state)
          IDLE: next_state = REQ;
          REQ: begin
            if (ack) begin
              if (stall) begin
                next_state = HOLD;
              end else begin
                upd_pc = 1'b1;
              end
            end
          end
          HOLD: begin
            if (!stall) begin
              upd_pc     = 1'b1;
              next_state = REQ;
            end
          end
          DROP: begin
            if (ack) begin
              next_state = REQ;
            end
          end
          default: next_state = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      epc      <= 32'd0;
      hold_buf <= 32'd0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      if (exc || irq_accept) begin
        epc <= pc;
      end
      if (state == REQ && ack && stall && !xfer) begin
        hold_buf <= imem.imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit: a variable-latency memory, an abstract fetch model
// feeding expected IF/ID events and fetch addresses into queues, and a negedge monitor.
module tb_if_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        exc = 1'b0;
  logic        irq = 1'b0;
  logic [31:0] out_inst, out_pc, epc;
  logic        upd_pc, flush, irq_taken;

  always #5 clk = ~clk;

  if_fetch_unit_if imem_bus ();

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc            (exc),
    .irq            (irq),
    .imem           (imem_bus),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .upd_pc         (upd_pc),
    .flush          (flush),
    .irq_taken      (irq_taken),
    .epc            (epc)
  );

  typedef struct {
    bit          upd;
    bit          flush;
    bit          irqt;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] epc_after;
  } ev_t;

  ev_t         ev_q[$];
  logic [31:0] addr_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          mon_en = 0;
  bit          epc_pending = 0;
  logic [31:0] epc_exp;

  // Reference model state: where the program counter is and what the fetcher is waiting on.
  logic [31:0] m_pc, m_epc, m_buf;
  bit          m_booted, m_held, m_stale;

  // Memory environment.
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr;
  int          lat_min = 0;
  int          lat_max = 0;
  bit          stray_ack = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_step();
    bit          ack;
    logic [31:0] rd;
    bit          fetching, take_irq, xfer;
    ev_t         ev;
    ack = imem_bus.imem_ack;
    rd  = imem_bus.imem_rdata;
    if (reset) begin
      m_pc = RESET_PC; m_epc = 0; m_buf = 0;
      m_booted = 0; m_held = 0; m_stale = 0;
      return;
    end
    fetching = m_booted && !m_held && !m_stale;
    if (fetching) addr_q.push_back(m_pc);
    take_irq = irq && (m_pc < 32'h8000_0000) && !exc && !redirect_valid;
    xfer     = exc || redirect_valid || take_irq;
    ev.upd = 0; ev.flush = 0; ev.irqt = 0; ev.inst = 0; ev.pc = 0; ev.epc_after = 0;
    if (xfer) begin
      if (exc || take_irq) m_epc = m_pc;
      ev.flush = 1; ev.irqt = take_irq; ev.epc_after = m_epc;
      ev_q.push_back(ev);
      if (exc) m_pc = EXC_VEC;
      else if (redirect_valid) m_pc = redirect_pc & 32'hFFFF_FFFC;
      else m_pc = IRQ_VEC;
      m_stale  = (m_stale || fetching) && !ack;
      m_held   = 0;
      m_booted = 1;
    end else if (!m_booted) begin
      m_booted = 1;
    end else if (m_stale) begin
      if (ack) m_stale = 0;
    end else if (m_held) begin
      if (!stall) begin
        ev.upd = 1; ev.inst = m_buf; ev.pc = m_pc + 4;
        ev_q.push_back(ev);
        m_pc = m_pc + 4; m_held = 0;
      end
    end else if (ack) begin
      if (stall) begin
        m_held = 1; m_buf = rd;
      end else begin
        ev.upd = 1; ev.inst = rd; ev.pc = m_pc + 4;
        ev_q.push_back(ev);
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit rv, input logic [31:0] rpc,
                     input bit e, input bit i);
    @(posedge clk);
    #1;
    reset = r; stall = s; redirect_valid = rv; redirect_pc = rpc; exc = e; irq = i;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = $urandom;
    if (r) begin
      mem_busy = 0;
    end else if (stray_ack) begin
      imem_bus.imem_ack = 1'b1;
      stray_ack = 0;
    end else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = mem_data(mem_addr);
        mem_busy = 0;
      end
    end else if (imem_bus.imem_req === 1'b1) begin
      mem_addr = imem_bus.imem_addr;
      mem_cnt  = $urandom_range(lat_max, lat_min);
      if (mem_cnt == 0) begin
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = mem_data(mem_addr);
      end else begin
        mem_busy = 1;
      end
    end
    model_step();
  endtask

  task automatic step();
    cyc(0, 0, 0, 32'd0, 0, 0);
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_min = lo; lat_max = hi;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " imem_req"},  {31'd0, imem_bus.imem_req}, 32'd0);
    chk({tag, " imem_addr"}, imem_bus.imem_addr, RESET_PC);
    chk({tag, " out_pc"},    out_pc, RESET_PC);
    chk({tag, " upd_pc"},    {31'd0, upd_pc}, 32'd0);
    chk({tag, " flush"},     {31'd0, flush}, 32'd0);
    chk({tag, " irq_taken"}, {31'd0, irq_taken}, 32'd0);
  endtask

  always @(negedge clk) begin
    ev_t ev;
    if (mon_en && epc_pending) begin
      chk("epc", epc, epc_exp);
      epc_pending = 0;
    end
    if (mon_en && !reset) begin
      if (imem_bus.imem_req === 1'b1) begin
        if (addr_q.size() == 0) begin
          n_checks++;
          $display("FAIL imem_req: got unexpected request to %h", imem_bus.imem_addr);
        end else begin
          chk("imem_addr", imem_bus.imem_addr, addr_q.pop_front());
        end
      end
      if (upd_pc === 1'b1 || flush === 1'b1 || irq_taken === 1'b1) begin
        if (ev_q.size() == 0) begin
          n_checks++;
          $display("FAIL ifid_event: got upd=%b flush=%b irq=%b with nothing expected",
                   upd_pc, flush, irq_taken);
        end else begin
          ev = ev_q.pop_front();
          chk("upd_pc", {31'd0, upd_pc}, {31'd0, ev.upd});
          chk("flush", {31'd0, flush}, {31'd0, ev.flush});
          chk("irq_taken", {31'd0, irq_taken}, {31'd0, ev.irqt});
          if (ev.upd) begin
            chk("out_inst", out_inst, ev.inst);
            chk("out_pc", out_pc, ev.pc);
          end
          if (ev.flush) begin
            epc_pending = 1;
            epc_exp = ev.epc_after;
          end
        end
      end
    end
  end

  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'd0;

    // Reset, then the idle cycle shows reset values.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    mon_en = 1;
    step();
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset out_inst", out_inst, 32'd0);
    chk("reset epc", epc, 32'd0);

    // Zero-wait streaming from the reset vector.
    set_lat(0, 0);
    repeat (4) step();

    // Three stalled cycles: the word is held and no new request goes out.
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("hold no req", {31'd0, imem_bus.imem_req}, 32'd0);
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("hold no req", {31'd0, imem_bus.imem_req}, 32'd0);
    step();

    // Redirect while a 3-wait read is outstanding; the stale ack is dropped.
    set_lat(3, 3);
    step();
    cyc(0, 0, 1, 32'h0000_1003, 0, 0);
    @(negedge clk);
    chk("redirect flush", {31'd0, flush}, 32'd1);
    repeat (3) step();
    @(negedge clk);
    chk("post-drop addr", imem_bus.imem_addr, 32'h0000_1000);
    chk("post-drop req", {31'd0, imem_bus.imem_req}, 32'd1);
    set_lat(0, 0);
    repeat (4) step();

    // User-mode interrupt, then none accepted from kernel mode.
    cyc(0, 0, 1, 32'h0000_2000, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("irq_taken user", {31'd0, irq_taken}, 32'd1);
    step();
    @(negedge clk);
    chk("irq epc", epc, 32'h0000_2000);
    chk("irq vector addr", imem_bus.imem_addr, IRQ_VEC);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("irq_taken kernel", {31'd0, irq_taken}, 32'd0);
    end

    // Exception beats redirect and interrupt in the same cycle.
    cyc(0, 0, 1, 32'h0000_2400, 0, 0);
    cyc(0, 0, 1, 32'h0000_3000, 1, 1);
    @(negedge clk);
    chk("exc irq_taken", {31'd0, irq_taken}, 32'd0);
    step();
    @(negedge clk);
    chk("exc vector addr", imem_bus.imem_addr, EXC_VEC);
    chk("exc epc", epc, 32'h0000_2400);

    // PC wraps modulo 2^32.
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step();
    @(negedge clk);
    chk("wrap out_pc", out_pc, 32'd0);
    step();
    @(negedge clk);
    chk("wrap addr", imem_bus.imem_addr, 32'd0);

    // Reset in the middle of a request; a late ack in IDLE is ignored.
    set_lat(3, 3);
    step();
    step();
    cyc(1, 0, 0, 0, 0, 0);
    stray_ack = 1;
    step();
    @(negedge clk);
    chk_reset_outputs("mid-req reset");
    step();
    @(negedge clk);
    chk("restart addr", imem_bus.imem_addr, RESET_PC);

    // Randomised traffic.
    set_lat(0, 3);
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(299, 0) == 0),
          ($urandom_range(9, 0) < 3),
          ($urandom_range(19, 0) == 0),
          $urandom,
          ($urandom_range(49, 0) == 0),
          ($urandom_range(9, 0) == 0));
    end
    step();
    @(negedge clk);
    #1;
    chk("events left", ev_q.size(), 32'd0);
    chk("addrs left", addr_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
